// File: rtl/inst_input_queue.sv
// Instruction input queue: captures instructions into a DEPTH-entry FIFO and
// replays them to the core over a valid/ready handshake.
module inst_input_queue #(
   parameter int DATA_W   = 8,
   parameter int OPCODE_W = 4,
   parameter int REG_W    = 2,
   parameter int DEPTH    = 4,
   parameter int CNT_W    = $clog2(DEPTH + 1)
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                instv,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic [DATA_W-1:0]   imm,
   input  logic [REG_W-1:0]    src1,
   input  logic [REG_W-1:0]    src2,
   input  logic [REG_W-1:0]    dst,
   input  logic                flush,
   output logic                in_ready,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [OPCODE_W-1:0] out_opcode,
   output logic [DATA_W-1:0]   out_imm,
   output logic [REG_W-1:0]    out_src1,
   output logic [REG_W-1:0]    out_src2,
   output logic [REG_W-1:0]    out_dst,
   output logic [CNT_W-1:0]    count,
   output logic                overflow
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int ENT_W = OPCODE_W + DATA_W + 3 * REG_W;

   logic [ENT_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_head;
   logic [PTR_W-1:0] r_tail;
   logic [CNT_W-1:0] r_count;
   logic             r_overflow;

   logic             w_full;
   logic             w_empty;
   logic             w_pop;
   logic             w_push;
   logic             w_drop;
   logic [ENT_W-1:0] w_entry;
   logic [ENT_W-1:0] w_head;

   assign w_full  = (r_count == CNT_W'(DEPTH));
   assign w_empty = (r_count == {CNT_W{1'b0}});
   assign w_pop   = !w_empty && out_ready;
   // A full queue still accepts a push when the head retires in the same cycle.
   assign w_push  = instv && (!w_full || w_pop);
   assign w_drop  = instv && w_full && !w_pop;
   assign w_entry = {opcode, imm, src1, src2, dst};

   // Control state: pointers, occupancy and sticky overflow.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_head     <= {PTR_W{1'b0}};
         r_tail     <= {PTR_W{1'b0}};
         r_count    <= {CNT_W{1'b0}};
         r_overflow <= 1'b0;
      end else if (flush) begin
         r_head  <= {PTR_W{1'b0}};
         r_tail  <= {PTR_W{1'b0}};
         r_count <= {CNT_W{1'b0}};
      end else begin
         if (w_push) begin
            r_tail <= r_tail + 1'b1;
         end
         if (w_pop) begin
            r_head <= r_head + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         if (w_drop) begin
            r_overflow <= 1'b1;
         end
      end
   end

   // Entry storage; contents are only ever observed through the head while valid.
   always_ff @(posedge clock) begin
      if (!reset && !flush && w_push) begin
         r_mem[r_tail] <= w_entry;
      end
   end

   assign w_head    = w_empty ? {ENT_W{1'b0}} : r_mem[r_head];
   assign out_valid = !w_empty;
   assign in_ready  = !w_full;
   assign count     = r_count;
   assign overflow  = r_overflow;
   assign {out_opcode, out_imm, out_src1, out_src2, out_dst} = w_head;

endmodule

// File: tb/tb_inst_input_queue.sv
// Self-checking bench for inst_input_queue: queue-based reference model compared
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_inst_input_queue;

   localparam int DATA_W   = 8;
   localparam int OPCODE_W = 4;
   localparam int REG_W    = 2;
   localparam int DEPTH    = 4;
   localparam int CNT_W    = $clog2(DEPTH + 1);
   localparam int ENT_W    = OPCODE_W + DATA_W + 3 * REG_W;

   logic                clock = 1'b0;
   logic                reset = 1'b1;
   logic                instv = 1'b0;
   logic [OPCODE_W-1:0] opcode = '0;
   logic [DATA_W-1:0]   imm = '0;
   logic [REG_W-1:0]    src1 = '0;
   logic [REG_W-1:0]    src2 = '0;
   logic [REG_W-1:0]    dst = '0;
   logic                flush = 1'b0;
   logic                in_ready;
   logic                out_valid;
   logic                out_ready = 1'b0;
   logic [OPCODE_W-1:0] out_opcode;
   logic [DATA_W-1:0]   out_imm;
   logic [REG_W-1:0]    out_src1;
   logic [REG_W-1:0]    out_src2;
   logic [REG_W-1:0]    out_dst;
   logic [CNT_W-1:0]    count;
   logic                overflow;

   int total = 0;
   int bad   = 0;

   logic [ENT_W-1:0] m_q[$];
   logic             m_ovf = 1'b0;

   inst_input_queue #(
      .DATA_W(DATA_W), .OPCODE_W(OPCODE_W), .REG_W(REG_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
   ) dut (
      .clock(clock), .reset(reset), .instv(instv), .opcode(opcode), .imm(imm),
      .src1(src1), .src2(src2), .dst(dst), .flush(flush), .in_ready(in_ready),
      .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
      .out_imm(out_imm), .out_src1(out_src1), .out_src2(out_src2), .out_dst(out_dst),
      .count(count), .overflow(overflow)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare every output against the reference model.
   task automatic check_model();
      logic [ENT_W-1:0] head;
      head = (m_q.size() != 0) ? m_q[0] : '0;
      chk("out_valid", int'(out_valid), int'(m_q.size() != 0));
      chk("in_ready", int'(in_ready), int'(m_q.size() != DEPTH));
      chk("count", int'(count), m_q.size());
      chk("overflow", int'(overflow), int'(m_ovf));
      chk("head", int'({out_opcode, out_imm, out_src1, out_src2, out_dst}), int'(head));
   endtask

   // One clock: model follows the rules with the inputs seen at the edge.
   task automatic step();
      logic pop;
      logic full;
      @(posedge clock);
      pop  = (m_q.size() != 0) && out_ready;
      full = (m_q.size() == DEPTH);
      if (reset) begin
         m_q.delete();
         m_ovf = 1'b0;
      end else if (flush) begin
         m_q.delete();
      end else begin
         if (pop) void'(m_q.pop_front());
         if (instv) begin
            if (!full || pop) m_q.push_back({opcode, imm, src1, src2, dst});
            else m_ovf = 1'b1;
         end
      end
      @(negedge clock);
      check_model();
   endtask

   task automatic set_inst(input int op, input int im, input int s1, input int s2, input int d);
      instv  = 1'b1;
      opcode = OPCODE_W'(op);
      imm    = DATA_W'(im);
      src1   = REG_W'(s1);
      src2   = REG_W'(s2);
      dst    = REG_W'(d);
   endtask

   task automatic idle_inputs();
      instv = 1'b0; out_ready = 1'b0; flush = 1'b0; reset = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   initial begin
      // Reset then idle
      do_reset();
      step();
      chk("rst_count", int'(count), 0);
      chk("rst_valid", int'(out_valid), 0);
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_ovf", int'(overflow), 0);
      chk("rst_imm", int'(out_imm), 0);

      // Single push, hold, then pop
      set_inst(3, 8'hA5, 1, 2, 3);
      step();
      instv = 1'b0;
      chk("one_valid", int'(out_valid), 1);
      chk("one_imm", int'(out_imm), 8'hA5);
      chk("one_regs", int'({out_src1, out_src2, out_dst}), 6'b01_10_11);
      chk("one_count", int'(count), 1);
      step();
      step();
      chk("one_hold", int'(out_imm), 8'hA5);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("one_popped", int'(out_valid), 0);

      // Fill, drop, drain in order
      for (int i = 1; i <= 4; i++) begin
         set_inst(i, i, 0, 0, 0);
         step();
      end
      chk("full_count", int'(count), 4);
      chk("full_in_ready", int'(in_ready), 0);
      set_inst(5, 5, 0, 0, 0);
      step();
      instv = 1'b0;
      chk("drop_ovf", int'(overflow), 1);
      chk("drop_count", int'(count), 4);
      out_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         chk("drain_order", int'(out_imm), i);
         step();
      end
      out_ready = 1'b0;
      chk("drain_empty", int'(out_valid), 0);
      chk("drain_ovf", int'(overflow), 1);

      // Full queue push+pop, then streaming across wrap
      do_reset();
      for (int i = 1; i <= 4; i++) begin
         set_inst(0, i, 0, 0, 0);
         step();
      end
      set_inst(0, 9, 0, 0, 0);
      out_ready = 1'b1;
      step();
      chk("pp_count", int'(count), 4);
      chk("pp_ovf", int'(overflow), 0);
      for (int i = 10; i <= 19; i++) begin
         set_inst(0, i, 0, 0, 0);
         step();
      end
      idle_inputs();
      chk("stream_head", int'(out_imm), 16);
      chk("stream_count", int'(count), 4);

      // Flush keeps overflow, drops same-cycle push
      set_inst(0, 20, 0, 0, 0);
      step();
      instv = 1'b0;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("pre_flush_count", int'(count), 3);
      set_inst(0, 21, 0, 0, 0);
      flush = 1'b1;
      step();
      idle_inputs();
      chk("flush_count", int'(count), 0);
      chk("flush_valid", int'(out_valid), 0);
      chk("flush_ovf", int'(overflow), 1);

      // Reset beats a same-cycle push
      set_inst(0, 30, 0, 0, 0);
      step();
      step();
      reset = 1'b1;
      step();
      idle_inputs();
      chk("rst_push_count", int'(count), 0);
      chk("rst_push_ovf", int'(overflow), 0);
      step();
      chk("rst_push_valid", int'(out_valid), 0);

      // Random traffic against the model
      for (int n = 0; n < 3000; n++) begin
         reset     = ($urandom_range(99) == 0);
         flush     = ($urandom_range(99) < 3);
         instv     = ($urandom_range(99) < 60);
         out_ready = ($urandom_range(99) < 45);
         opcode    = OPCODE_W'($urandom);
         imm       = DATA_W'($urandom);
         src1      = REG_W'($urandom);
         src2      = REG_W'($urandom);
         dst       = REG_W'($urandom);
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
